// File: rtl/wb_to_av_bridge_if.sv
// Bus bundle for the Wishbone-slave / Avalon-MM-master bridge.
// slave = the bridge itself, master = the Wishbone initiator plus the Avalon agent.
interface wb_to_av_bridge_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;
    logic              av_readdatavalid;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output av_address, av_read, av_write, av_writedata, av_byteenable,
        input  av_readdata, av_waitrequest, av_readdatavalid
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  av_address, av_read, av_write, av_writedata, av_byteenable,
        output av_readdata, av_waitrequest, av_readdatavalid
    );
endinterface

// File: rtl/wb_to_av_bridge.sv
// Single-outstanding Wishbone classic slave to Avalon-MM master bridge with
// a per-transfer timeout that terminates stuck accesses with wb_err_o.
module wb_to_av_bridge #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input logic              av_clk,
    input logic              av_reset_n,
    wb_to_av_bridge_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             we_q;

    logic accept_c;
    logic data_c;
    logic tmo_hit_c;

    assign accept_c  = (state == REQ) && !bus.av_waitrequest;
    // Read data counts only once the command has been accepted.
    assign data_c    = bus.av_readdatavalid && !we_q && (accept_c || (state == RDATA));
    assign tmo_hit_c = (tmo_cnt + CNT_W'(1)) == TIMEOUT_CNT;

    always_ff @(posedge av_clk or negedge av_reset_n) begin
        if (!av_reset_n) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            we_q              <= 1'b0;
            bus.wb_dat_o      <= '0;
            bus.wb_ack_o      <= 1'b0;
            bus.wb_err_o      <= 1'b0;
            bus.av_address    <= '0;
            bus.av_read       <= 1'b0;
            bus.av_write      <= 1'b0;
            bus.av_writedata  <= '0;
            bus.av_byteenable <= '0;
        end else begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The error cycle is the initiator's termination edge, not a new request.
                    if (bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_err_o) begin
                        bus.av_address   <= ADDR_W'(bus.wb_adr_i);
                        bus.av_writedata <= bus.wb_dat_i;
                        we_q             <= bus.wb_we_i;
                        tmo_cnt          <= '0;
                        if (bus.wb_we_i && (bus.wb_sel_i == 4'h0)) begin
                            bus.av_byteenable <= 4'h0;
                            bus.wb_ack_o      <= 1'b1;
                            state             <= RESP;
                        end else begin
                            bus.av_byteenable <= bus.wb_we_i ? bus.wb_sel_i : 4'hF;
                            bus.av_read       <= !bus.wb_we_i;
                            bus.av_write      <= bus.wb_we_i;
                            state             <= REQ;
                        end
                    end
                end
                REQ, RDATA: begin
                    if ((accept_c && we_q) || data_c) begin
                        if (data_c) begin
                            bus.wb_dat_o <= bus.av_readdata;
                        end
                        bus.av_read  <= 1'b0;
                        bus.av_write <= 1'b0;
                        bus.wb_ack_o <= bus.wb_cyc_i;
                        state        <= RESP;
                    end else if (tmo_hit_c) begin
                        bus.av_read  <= 1'b0;
                        bus.av_write <= 1'b0;
                        bus.wb_err_o <= bus.wb_cyc_i;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        if (accept_c) begin
                            bus.av_read <= 1'b0;
                            state       <= RDATA;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_to_av_bridge.sv
// Self-checking bench for wb_to_av_bridge: directed vector table, corner sequences
// and randomized transfers checked against a transfer-level timing model.
module tb_wb_to_av_bridge;
    localparam int unsigned ADDR_W = 8;
    localparam int          TMO    = 8;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          wt;     // cycles av_waitrequest stays high
        int          lat;    // cycles from acceptance to readdatavalid
        logic [31:0] rdata;
        int          gap;    // idle cycles after termination
        logic        stray;  // stray readdatavalid in the termination cycle
    } txn_t;

    typedef struct {
        int          cmd_n;  // cycles the Avalon command is visible
        int          term;   // cycle (after strobe sample) of ack or err
        logic        err;
        logic [31:0] dat;    // wb_dat_o from the termination cycle on
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    logic av_clk = 1'b0;
    logic av_reset_n;
    always #5 av_clk = ~av_clk;

    wb_to_av_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    wb_to_av_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .av_clk    (av_clk),
        .av_reset_n(av_reset_n),
        .bus       (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_dat = 32'h0;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge av_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                                input logic [3:0] sel, input int wt, input int lat,
                                input logic [31:0] rdata, input int gap, input logic stray,
                                input int cmd_n, input int term, input logic err,
                                input logic [31:0] dat);
        vec_t v;
        v.t.we = we; v.t.adr = adr; v.t.wdat = wdat; v.t.sel = sel; v.t.wt = wt;
        v.t.lat = lat; v.t.rdata = rdata; v.t.gap = gap; v.t.stray = stray;
        v.e.cmd_n = cmd_n; v.e.term = term; v.e.err = err; v.e.dat = dat;
        return v;
    endfunction

    // Transfer-level reference: when the access finishes versus the timeout budget.
    function automatic exp_t model(input txn_t t, input logic [31:0] prev);
        exp_t e;
        int   done;
        if (t.we && (t.sel == 4'h0)) begin
            e.cmd_n = 0; e.term = 1; e.err = 1'b0; e.dat = prev;
            return e;
        end
        done = t.we ? t.wt + 1 : t.wt + 1 + t.lat;
        if (done <= TMO) begin
            e.cmd_n = t.wt + 1; e.term = done + 1; e.err = 1'b0;
            e.dat   = t.we ? prev : t.rdata;
        end else begin
            e.cmd_n = (t.wt + 1 < TMO) ? t.wt + 1 : TMO;
            e.term  = TMO + 1; e.err = 1'b1; e.dat = prev;
        end
        return e;
    endfunction

    task automatic run_txn(input txn_t t, input exp_t e);
        logic [31:0] prev;
        logic        exp_cmd;
        logic        rdv_now;
        prev = model_dat;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = t.we;
        bus.wb_adr_i = t.adr; bus.wb_dat_i = t.wdat; bus.wb_sel_i = t.sel;
        tick();
        for (int k = 1; k <= e.term; k++) begin
            rdv_now = !t.we && (k == t.wt + 1 + t.lat);
            bus.av_waitrequest = (k <= t.wt);
            if ((k == e.term) && t.stray) begin
                bus.av_readdatavalid = 1'b1;
                bus.av_readdata      = 32'hDEADBEEF;
            end else begin
                bus.av_readdatavalid = rdv_now;
                bus.av_readdata      = rdv_now ? t.rdata : $urandom();
            end
            exp_cmd = (k <= e.cmd_n);
            chk("av_read", 32'(bus.av_read), 32'(exp_cmd && !t.we));
            chk("av_write", 32'(bus.av_write), 32'(exp_cmd && t.we));
            if (exp_cmd) begin
                chk("av_address", 32'(bus.av_address), 32'(t.adr));
                chk("av_byteenable", 32'(bus.av_byteenable), 32'(t.we ? t.sel : 4'hF));
                if (t.we) chk("av_writedata", bus.av_writedata, t.wdat);
            end
            chk("wb_ack_o", 32'(bus.wb_ack_o), 32'((k == e.term) && !e.err));
            chk("wb_err_o", 32'(bus.wb_err_o), 32'((k == e.term) && e.err));
            chk("wb_dat_o", bus.wb_dat_o, (k >= e.term) ? e.dat : prev);
            tick();
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        bus.av_readdatavalid = 1'b0; bus.av_waitrequest = 1'($urandom_range(0, 1));
        model_dat = e.dat;
        repeat (t.gap) begin
            chk("wb_dat_o idle", bus.wb_dat_o, model_dat);
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acks;
        txn_t rt;

        av_reset_n = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.av_readdata = '0; bus.av_waitrequest = 1'b0; bus.av_readdatavalid = 1'b0;

        repeat (2) tick();
        chk("reset wb_ack_o", 32'(bus.wb_ack_o), 32'h0);
        chk("reset wb_err_o", 32'(bus.wb_err_o), 32'h0);
        chk("reset av_read", 32'(bus.av_read), 32'h0);
        chk("reset av_write", 32'(bus.av_write), 32'h0);
        chk("reset wb_dat_o", bus.wb_dat_o, 32'h0);
        chk("reset av_address", 32'(bus.av_address), 32'h0);
        chk("reset av_byteenable", 32'(bus.av_byteenable), 32'h0);
        @(negedge av_clk);
        av_reset_n = 1'b1;

        //           we    adr    wdat          sel   wt lat rdata         gap stray  cmd term err  dat
        vecs.push_back(mk(1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 0, 0, 32'h0,        1, 1'b0, 1, 2, 1'b0, 32'h00000000));
        vecs.push_back(mk(1'b0, 8'h04, 32'h0,        4'h0, 3, 2, 32'h12345678, 0, 1'b0, 4, 7, 1'b0, 32'h12345678));
        vecs.push_back(mk(1'b0, 8'h08, 32'h0,        4'h3, 0, 0, 32'hA5A5A5A5, 1, 1'b1, 1, 2, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b0, 8'h0C, 32'h0,        4'hF, 20, 0, 32'h77777777, 2, 1'b1, 8, 9, 1'b1, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, 8'h20, 32'h11112222, 4'h0, 0, 0, 32'h0,        0, 1'b0, 0, 1, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, 8'h21, 32'h33334444, 4'h0, 0, 0, 32'h0,        0, 1'b1, 0, 1, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, 8'h30, 32'h89ABCDEF, 4'hF, 7, 0, 32'h0,        1, 1'b0, 8, 9, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, 8'h31, 32'h01020304, 4'hC, 8, 0, 32'h0,        1, 1'b0, 8, 9, 1'b1, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b0, 8'h40, 32'h0,        4'h0, 2, 5, 32'h0BADF00D, 0, 1'b0, 3, 9, 1'b0, 32'h0BADF00D));
        vecs.push_back(mk(1'b0, 8'h41, 32'h0,        4'h0, 2, 6, 32'h11111111, 1, 1'b0, 3, 9, 1'b1, 32'h0BADF00D));
        vecs.push_back(mk(1'b1, 8'h50, 32'h55AA55AA, 4'h5, 1, 0, 32'h0,        2, 1'b0, 2, 3, 1'b0, 32'h0BADF00D));

        foreach (vecs[i]) run_txn(vecs[i].t, vecs[i].e);

        // Strobe held high across zero-select writes: one ack per two cycles.
        acks = 0;
        bus.av_waitrequest = 1'b0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 8'h60; bus.wb_sel_i = 4'h0;
        tick();
        for (int k = 1; k <= 7; k++) begin
            chk("held ack", 32'(bus.wb_ack_o), 32'((k % 2 == 1) && (k < 7)));
            chk("held av_write", 32'(bus.av_write), 32'h0);
            if (bus.wb_ack_o) acks++;
            if (k == 6) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
            tick();
        end
        chk("held ack count", 32'(acks), 32'd3);

        // Cycle dropped mid-transfer: command finishes, no termination pulse.
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 8'h22; bus.wb_dat_i = 32'hFEEDBEEF; bus.wb_sel_i = 4'h3;
        tick();
        for (int k = 1; k <= 6; k++) begin
            bus.av_waitrequest = (k <= 3);
            chk("cycdrop av_write", 32'(bus.av_write), 32'(k <= 4));
            chk("cycdrop wb_ack_o", 32'(bus.wb_ack_o), 32'h0);
            chk("cycdrop wb_err_o", 32'(bus.wb_err_o), 32'h0);
            if (k == 2) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
            tick();
        end

        for (int n = 0; n < 40; n++) begin
            rt.we    = 1'($urandom_range(0, 1));
            rt.adr   = 8'($urandom);
            rt.wdat  = $urandom();
            rt.sel   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rt.wt    = $urandom_range(0, 9);
            rt.lat   = $urandom_range(0, 4);
            rt.rdata = $urandom();
            rt.gap   = $urandom_range(0, 2);
            rt.stray = 1'($urandom_range(0, 1));
            run_txn(rt, model(rt, model_dat));
        end

        // Reset pulsed while the read command is pending.
        bus.av_waitrequest = 1'b1; bus.av_readdatavalid = 1'b0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 8'h6A; bus.wb_sel_i = 4'hF;
        tick();
        chk("prerst av_read", 32'(bus.av_read), 32'h1);
        #2 av_reset_n = 1'b0;
        #1;
        chk("rst async av_read", 32'(bus.av_read), 32'h0);
        chk("rst async av_write", 32'(bus.av_write), 32'h0);
        chk("rst async av_address", 32'(bus.av_address), 32'h0);
        chk("rst async wb_dat_o", bus.wb_dat_o, 32'h0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        tick();
        chk("rst wb_ack_o", 32'(bus.wb_ack_o), 32'h0);
        chk("rst wb_err_o", 32'(bus.wb_err_o), 32'h0);
        @(negedge av_clk);
        av_reset_n = 1'b1;
        model_dat = 32'h0;
        run_txn(vecs[0].t, model(vecs[0].t, model_dat));
        run_txn(vecs[2].t, model(vecs[2].t, model_dat));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
